if_id_queue: RTL

//  Decoupling buffer between the fetch stage and the decode stage.

---
 rtl/if_id_queue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   A buffer between the fetch stage and the decode stage. It captures each
//   fetched {pc, pc+4, instruction} triple in a DEPTH-entry FIFO and shows the
//   oldest entry to ID. Both sides use valid/ready, so an ID stall never loses
//   a fetched instruction. A redirect flush discards every wrong-path entry in
//   one cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high and flush_in is low. if_ready_out and id_valid_out depend only
//   on the registered occupancy. They never depend on same-cycle inputs.
//
// Ports
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   flush_in            drop all stored entries and any same-cycle push
//   if_valid_in/_pc_in/_pc_plus_4_in/_instr_in   fetch-side push triple
//   if_ready_out        queue has room (count != DEPTH)
//   id_valid_out        head entry valid (count != 0)
//   id_pc_out/_pc_plus_4_out/_instr_out          head triple (0/0/NOP if empty)
//   id_ready_in         ID consumes the head this cycle
//   count_out           occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int              XLEN  = 32,
    parameter int              DEPTH = 2,
    parameter logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_in,
    input  logic                       if_valid_in,
    input  logic [XLEN-1:0]            if_pc_in,
    input  logic [XLEN-1:0]            if_pc_plus_4_in,
    input  logic [XLEN-1:0]            if_instr_in,
    output logic                       if_ready_out,
    output logic                       id_valid_out,
    output logic [XLEN-1:0]            id_pc_out,
    output logic [XLEN-1:0]            id_pc_plus_4_out,
    output logic [XLEN-1:0]            id_instr_out,
    input  logic                       id_ready_in,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);

    localparam int              CW       = $clog2(DEPTH + 1);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
        logic [XLEN-1:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;
    entry_t        head;

    // An explicit wrap compare keeps non-power-of-2 depths correct.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        if_ready_out = (count_q != FULL_CNT);
        id_valid_out = (count_q != '0);
        push         = if_valid_in & if_ready_out & ~flush_in;
        pop          = id_valid_out & id_ready_in & ~flush_in;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush_in) begin
            // Emptying the queue by pulling rd_ptr up to wr_ptr avoids touching storage.
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is not reset. Only the head pointer and count qualify it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc: if_pc_in, pc_plus_4: if_pc_plus_4_in, instr: if_instr_in};
        end
    end

    always_comb begin
        head             = mem_q[rd_ptr_q];
        id_pc_out        = id_valid_out ? head.pc        : '0;
        id_pc_plus_4_out = id_valid_out ? head.pc_plus_4 : '0;
        id_instr_out     = id_valid_out ? head.instr     : NOP;
        count_out        = count_q;
    end

`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge clk) disable iff (!rst) count_q <= FULL_CNT);
    a_push_room: assert property (@(posedge clk) disable iff (!rst) push |-> (count_q < FULL_CNT));
    a_pop_data:  assert property (@(posedge clk) disable iff (!rst) pop |-> (count_q != '0));
`endif

endmodule
